// File: rtl/tx_sample_pacer.sv
// tx_sample_pacer: host-fed I/Q FIFO that begins emitting pairs at a
// programmed 48-bit tick. After that it emits one pair every (period + 1)
// clocks toward the TX chain. If a slot finds fewer than two words queued,
// it emits (0,0) and counts an underflow. The whole block runs in the
// adc_clk domain.
module tx_sample_pacer #(
   parameter int DEPTH_LOG2 = 9,
   parameter int WORD_W     = 16
) (
   input  logic                  adc_clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [WORD_W-1:0]     wr_data,
   input  logic                  set_rate,
   input  logic [15:0]           rate_in,
   input  logic                  set_start,
   input  logic [47:0]           start_tick,
   input  logic                  abort,
   input  logic [47:0]           ticks_A,
   output logic [WORD_W-1:0]     tx_i_A,
   output logic [WORD_W-1:0]     tx_q_A,
   output logic                  tx_strobe_A,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic                  fifo_full,
   output logic                  wr_drop,
   output logic [15:0]           underflow_cnt,
   output logic [1:0]            state
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_enter_run;
   logic                  w_load_start;
   logic                  w_slot;

   logic [15:0]           r_period;
   logic [15:0]           r_cnt;
   logic [47:0]           r_start_tick;

   logic [WORD_W-1:0]     r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2-1:0] w_rd_ptr_p1;
   logic [LW-1:0]         r_level;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_drop_set;

   logic [WORD_W-1:0]     r_tx_i;
   logic [WORD_W-1:0]     r_tx_q;
   logic                  r_strobe;
   logic [15:0]           r_ucnt;
   logic                  r_wr_drop;

   // The write parity (I or Q next) always equals the LSB of r_level.
   // Pops only ever remove whole pairs, and writes are dropped only when
   // the FIFO is full. A pop requires two words, so a lone I word is
   // never emitted on its own.
   assign w_full      = (r_level == LW'(DEPTH));
   assign w_push      = wr_en && !w_full && !abort;
   assign w_drop_set  = wr_en &&  w_full && !abort;
   assign w_pop       = w_slot && (r_level > LW'(1));
   assign w_rd_ptr_p1 = r_rd_ptr + DEPTH_LOG2'(1);

   // State register for the IDLE / ARMED / RUN sequencer.
   // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic and slot decode. abort overrides everything.
   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt  = r_state;
      w_enter_run  = 1'b0;
      w_load_start = 1'b0;
      w_slot       = 1'b0;
      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (set_start) begin
                  w_load_start = 1'b1;
                  w_state_nxt  = ST_ARMED;
               end
            end
            ST_ARMED: begin
               // A fresh set_start re-arms; the compare resumes next cycle.
               if (set_start) begin
                  w_load_start = 1'b1;
               end else if (ticks_A >= r_start_tick) begin
                  w_enter_run = 1'b1;
                  w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               w_slot = (r_cnt == 16'd0);
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Period and start-tick registers. The period survives abort.
   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset) begin
         r_period     <= 16'd0;
         r_start_tick <= 48'd0;
      end else begin
         if (!abort && set_rate) r_period <= rate_in;
         if (w_load_start)       r_start_tick <= start_tick;
      end
   end

   // Period counter. It is cleared on entry to RUN so the first RUN cycle
   // is a slot, and reloads from r_period only at a slot. A rate change
   // therefore never cuts a period short.
   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset) begin
         r_cnt <= 16'd0;
      end else if (abort || w_enter_run) begin
         r_cnt <= 16'd0;
      end else if (r_state == ST_RUN) begin
         if (r_cnt == 16'd0) r_cnt <= r_period;
         else                r_cnt <= r_cnt - 16'd1;
      end
   end

   // Sample storage write port.
   // NOTE: the storage array has no reset; valid contents are tracked by the pointers and level.
   always_ff @(posedge adc_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

   // FIFO pointers and level. A write and a pop can occur in the same cycle.
   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (abort) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(2);
         r_level <= r_level + LW'(w_push) - (w_pop ? LW'(2) : LW'(0));
      end
   end

   // Emit path. Each slot produces one strobe on the following cycle,
   // carrying either the popped pair or (0,0) for an underflow.
   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset) begin
         r_tx_i   <= '0;
         r_tx_q   <= '0;
         r_strobe <= 1'b0;
         r_ucnt   <= 16'd0;
      end else if (abort) begin
         r_tx_i   <= '0;
         r_tx_q   <= '0;
         r_strobe <= 1'b0;
         r_ucnt   <= 16'd0;
      end else if (w_slot) begin
         r_strobe <= 1'b1;
         if (w_pop) begin
            r_tx_i <= r_mem[r_rd_ptr];
            r_tx_q <= r_mem[w_rd_ptr_p1];
         end else begin
            r_tx_i <= '0;
            r_tx_q <= '0;
            if (r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 16'd1;
         end
      end else begin
         r_strobe <= 1'b0;
      end
   end

   // Sticky flag for a write discarded by a full FIFO. Only abort or reset clears it.
   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset)           r_wr_drop <= 1'b0;
      else if (abort)      r_wr_drop <= 1'b0;
      else if (w_drop_set) r_wr_drop <= 1'b1;
   end

   assign tx_i_A        = r_tx_i;
   assign tx_q_A        = r_tx_q;
   assign tx_strobe_A   = r_strobe;
   assign fifo_level    = r_level;
   assign fifo_full     = w_full;
   assign wr_drop       = r_wr_drop;
   assign underflow_cnt = r_ucnt;
   assign state         = r_state;

endmodule

// File: tb/tb_tx_sample_pacer.sv
// Directed bench for tx_sample_pacer. Inputs are driven 1 ns after the
// rising edge, and outputs are sampled in that same window.
module tb_tx_sample_pacer;

   logic         adc_clk = 1'b0;
   logic         reset;
   logic         wr_en;
   logic [15:0]  wr_data;
   logic         set_rate;
   logic [15:0]  rate_in;
   logic         set_start;
   logic [47:0]  start_tick;
   logic         abort;
   logic [47:0]  ticks = 48'd0;
   logic [15:0]  tx_i_A;
   logic [15:0]  tx_q_A;
   logic         tx_strobe_A;
   logic [9:0]   fifo_level;
   logic         fifo_full;
   logic         wr_drop;
   logic [15:0]  underflow_cnt;
   logic [1:0]   state;

   int total = 0;
   int bad   = 0;

   tx_sample_pacer #(.DEPTH_LOG2(9), .WORD_W(16)) dut (
      .adc_clk       (adc_clk),
      .reset         (reset),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .set_rate      (set_rate),
      .rate_in       (rate_in),
      .set_start     (set_start),
      .start_tick    (start_tick),
      .abort         (abort),
      .ticks_A       (ticks),
      .tx_i_A        (tx_i_A),
      .tx_q_A        (tx_q_A),
      .tx_strobe_A   (tx_strobe_A),
      .fifo_level    (fifo_level),
      .fifo_full     (fifo_full),
      .wr_drop       (wr_drop),
      .underflow_cnt (underflow_cnt),
      .state         (state)
   );

   always #5 adc_clk = ~adc_clk;

   // Free-running timebase shared with the DUT.
   always @(posedge adc_clk) ticks <= ticks + 48'd1;

   // Watchdog: ensures the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge adc_clk);
      #1;
   endtask

   task automatic step_n(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic push(input logic [15:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic program_rate(input logic [15:0] r);
      set_rate = 1'b1;
      rate_in  = r;
      step();
      set_rate = 1'b0;
   endtask

   // Arm with a start tick in the past: ARMED after this step, RUN after the next.
   task automatic arm_now();
      set_start  = 1'b1;
      start_tick = 48'd0;
      step();
      set_start  = 1'b0;
   endtask

   task automatic wait_strobe(input int limit, output int gap);
      gap = 0;
      do begin
         step();
         gap++;
      end while (!tx_strobe_A && gap < limit);
      if (!tx_strobe_A) check("strobe_timeout", 64'(tx_strobe_A), 64'd1);
   endtask

   initial begin
      int gap;
      logic [31:0] t3_pair [5];
      logic [9:0]  t3_lvl  [5];

      reset = 1'b1; wr_en = 1'b0; wr_data = '0; set_rate = 1'b0; rate_in = '0;
      set_start = 1'b0; start_tick = '0; abort = 1'b0;

      // Reset values.
      step_n(2);
      check("rst_state",  64'(state), 64'd0);
      check("rst_level",  64'(fifo_level), 64'd0);
      check("rst_full",   64'(fifo_full), 64'd0);
      check("rst_strobe", 64'(tx_strobe_A), 64'd0);
      check("rst_drop",   64'(wr_drop), 64'd0);
      check("rst_ucnt",   64'(underflow_cnt), 64'd0);
      check("rst_iq",     64'({tx_i_A, tx_q_A}), 64'd0);
      reset = 1'b0;
      step();

      // T1: rate 3, two pairs, start 10 ticks ahead.
      program_rate(16'd3);
      push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
      check("t1_level", 64'(fifo_level), 64'd4);
      set_start  = 1'b1;
      start_tick = ticks + 48'd10;
      step();
      set_start  = 1'b0;
      check("t1_armed", 64'(state), 64'd1);
      step_n(9);
      check("t1_still_armed", 64'(state), 64'd1);
      step();
      check("t1_run", 64'(state), 64'd2);
      check("t1_no_strobe_yet", 64'(tx_strobe_A), 64'd0);
      step();
      check("t1_strobe1", 64'(tx_strobe_A), 64'd1);
      check("t1_pair1", 64'({tx_i_A, tx_q_A}), 64'h1111_2222);
      wait_strobe(10, gap);
      check("t1_gap2", 64'(gap), 64'd4);
      check("t1_pair2", 64'({tx_i_A, tx_q_A}), 64'h3333_4444);
      wait_strobe(10, gap);
      check("t1_gap3", 64'(gap), 64'd4);
      check("t1_pair3_under", 64'({tx_i_A, tx_q_A}), 64'd0);
      check("t1_ucnt", 64'(underflow_cnt), 64'd1);

      // T2: fill 512 words, one extra is dropped and never emitted.
      do_abort();
      for (int k = 0; k < 512; k++) push(16'(k));
      check("t2_full_before_extra", 64'(fifo_full), 64'd1);
      check("t2_drop_before_extra", 64'(wr_drop), 64'd0);
      push(16'hDEAD);
      check("t2_full", 64'(fifo_full), 64'd1);
      check("t2_level", 64'(fifo_level), 64'd512);
      check("t2_drop", 64'(wr_drop), 64'd1);
      program_rate(16'd0);
      arm_now();
      step();
      check("t2_run", 64'(state), 64'd2);
      for (int p = 0; p < 256; p++) begin
         wait_strobe(4, gap);
         check("t2_pair", 64'({tx_i_A, tx_q_A}), 64'({16'(2 * p), 16'(2 * p + 1)}));
      end
      wait_strobe(4, gap);
      check("t2_after_last_under", 64'({tx_i_A, tx_q_A}), 64'd0);
      check("t2_after_last_ucnt", 64'(underflow_cnt), 64'd1);
      check("t2_drop_sticky", 64'(wr_drop), 64'd1);
      do_abort();
      check("t2_drop_cleared", 64'(wr_drop), 64'd0);

      // T3: rate 0, 4 words preloaded, one host write per cycle while running.
      program_rate(16'd0);
      push(16'hA000); push(16'hA001); push(16'hA002); push(16'hA003);
      arm_now();
      step();
      check("t3_run", 64'(state), 64'd2);
      check("t3_level0", 64'(fifo_level), 64'd4);
      t3_pair[0] = 32'hA000_A001; t3_lvl[0] = 10'd3;
      t3_pair[1] = 32'hA002_A003; t3_lvl[1] = 10'd2;
      t3_pair[2] = 32'hB000_B001; t3_lvl[2] = 10'd1;
      t3_pair[3] = 32'h0000_0000; t3_lvl[3] = 10'd2;
      t3_pair[4] = 32'hB002_B003; t3_lvl[4] = 10'd1;
      for (int c = 0; c < 5; c++) begin
         wr_en   = 1'b1;
         wr_data = 16'hB000 + 16'(c);
         step();
         check("t3_strobe", 64'(tx_strobe_A), 64'd1);
         check("t3_pair", 64'({tx_i_A, tx_q_A}), 64'(t3_pair[c]));
         check("t3_level", 64'(fifo_level), 64'(t3_lvl[c]));
      end
      wr_en = 1'b0;
      step();
      check("t3_lone_i_strobe", 64'(tx_strobe_A), 64'd1);
      check("t3_lone_i_under", 64'({tx_i_A, tx_q_A}), 64'd0);
      check("t3_lone_i_level", 64'(fifo_level), 64'd1);
      check("t3_ucnt", 64'(underflow_cnt), 64'd2);

      // T4: three words, one valid pair then underflow with level 1.
      do_abort();
      program_rate(16'd1);
      push(16'hC000); push(16'hC001); push(16'hC002);
      arm_now();
      step();
      step();
      check("t4_pair", 64'({tx_i_A, tx_q_A}), 64'hC000_C001);
      check("t4_level", 64'(fifo_level), 64'd1);
      step();
      check("t4_gap_strobe", 64'(tx_strobe_A), 64'd0);
      step();
      check("t4_under_strobe", 64'(tx_strobe_A), 64'd1);
      check("t4_under_pair", 64'({tx_i_A, tx_q_A}), 64'd0);
      check("t4_under_level", 64'(fifo_level), 64'd1);
      check("t4_ucnt", 64'(underflow_cnt), 64'd1);

      // T5: abort mid-RUN with 10 words queued; the period is retained.
      do_abort();
      program_rate(16'd50);
      arm_now();
      step();
      step();
      check("t5_first_under", 64'(underflow_cnt), 64'd1);
      for (int k = 0; k < 10; k++) push(16'hD000 + 16'(k));
      check("t5_level10", 64'(fifo_level), 64'd10);
      check("t5_still_run", 64'(state), 64'd2);
      abort   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 16'hFFFF;
      step();
      abort   = 1'b0;
      wr_en   = 1'b0;
      check("t5_state", 64'(state), 64'd0);
      check("t5_level", 64'(fifo_level), 64'd0);
      check("t5_strobe", 64'(tx_strobe_A), 64'd0);
      check("t5_ucnt", 64'(underflow_cnt), 64'd0);
      check("t5_iq", 64'({tx_i_A, tx_q_A}), 64'd0);
      check("t5_drop", 64'(wr_drop), 64'd0);
      step_n(3);
      check("t5_quiet", 64'(tx_strobe_A), 64'd0);
      push(16'hE000); push(16'hE001); push(16'hE002); push(16'hE003);
      arm_now();
      step();
      check("t5_rerun", 64'(state), 64'd2);
      step();
      check("t5_parity_pair", 64'({tx_i_A, tx_q_A}), 64'hE000_E001);
      wait_strobe(60, gap);
      check("t5_period_kept", 64'(gap), 64'd51);
      check("t5_pair2", 64'({tx_i_A, tx_q_A}), 64'hE002_E003);

      // T6: rate 7 -> 1 mid-period; the current 8-cycle spacing completes.
      do_abort();
      program_rate(16'd7);
      for (int k = 0; k < 8; k++) push(16'hF000 + 16'(k));
      arm_now();
      step();
      step();
      check("t6_pair1", 64'({tx_i_A, tx_q_A}), 64'hF000_F001);
      step_n(2);
      program_rate(16'd1);
      // 3 cycles are already used, so 5 more complete the 8-cycle spacing.
      wait_strobe(20, gap);
      check("t6_gap_old", 64'(gap), 64'd5);
      check("t6_pair2", 64'({tx_i_A, tx_q_A}), 64'hF002_F003);
      wait_strobe(20, gap);
      check("t6_gap_new1", 64'(gap), 64'd2);
      wait_strobe(20, gap);
      check("t6_gap_new2", 64'(gap), 64'd2);
      check("t6_level", 64'(fifo_level), 64'd0);

      // Reset asserted mid-RUN takes effect without a clock edge.
      push(16'h5555); push(16'h6666); push(16'h7777);
      check("rst2_pre_state", 64'(state), 64'd2);
      #2;
      reset = 1'b1;
      #1;
      check("rst2_state", 64'(state), 64'd0);
      check("rst2_level", 64'(fifo_level), 64'd0);
      check("rst2_strobe", 64'(tx_strobe_A), 64'd0);
      check("rst2_ucnt", 64'(underflow_cnt), 64'd0);
      step();
      reset = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
